// File: rtl/vpu_req_issuer_pkg.sv
// rtl/vpu_req_issuer_pkg.sv - shared widths, request struct and issuer state type
package vpu_req_issuer_pkg;

  localparam int SRAM_R_PORT_CNT = 2;
  localparam int ADDR_W          = 16;
  localparam int OP_W            = 5;

  // src_addr[k] occupies bits [k*ADDR_W +: ADDR_W] of the packed field,
  // so it lines up with the flat host/controller address buses.
  typedef struct packed {
    logic [OP_W-1:0]                        opcode;
    logic [SRAM_R_PORT_CNT-1:0][ADDR_W-1:0] src_addr;
    logic [SRAM_R_PORT_CNT-1:0]             rvalid;
    logic [ADDR_W-1:0]                      dst_addr;
  } vpu_req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RSP
  } issuer_state_t;

endpackage

// File: rtl/vpu_cmd_fifo.sv
// rtl/vpu_cmd_fifo.sv - synchronous command FIFO with extra-MSB pointer wrap
module vpu_cmd_fifo
  import vpu_req_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  vpu_req_t push_data,
  input  logic     pop,
  output vpu_req_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  vpu_req_t       mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // Same index with differing wrap bit means every slot is occupied.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Advance pointers; pushes into a full FIFO and pops from an empty one are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage array needs no reset; only entries behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/vpu_req_issuer.sv
// rtl/vpu_req_issuer.sv - queues host commands and issues them one at a time to the VPU controller
module vpu_req_issuer
  import vpu_req_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W  = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic [OP_W-1:0]                   cmd_opcode_i,
  input  logic [SRAM_R_PORT_CNT*ADDR_W-1:0] cmd_src_addr_i,
  input  logic [SRAM_R_PORT_CNT-1:0]        cmd_rvalid_i,
  input  logic [ADDR_W-1:0]                 cmd_dst_addr_i,
  output logic                              req_valid_o,
  input  logic                              req_ready_i,
  output logic [OP_W-1:0]                   req_opcode_o,
  output logic [SRAM_R_PORT_CNT*ADDR_W-1:0] req_src_addr_o,
  output logic [SRAM_R_PORT_CNT-1:0]        req_rvalid_o,
  output logic [ADDR_W-1:0]                 req_dst_addr_o,
  input  logic                              wb_done_i,
  output logic                              rsp_valid_o,
  output logic                              rsp_timeout_o,
  output logic                              busy_o,
  output logic [15:0]                       issued_cnt_o
);

  vpu_req_t            push_data;
  vpu_req_t            head;
  vpu_req_t            req_q;
  logic                full;
  logic                empty;
  logic                pop;
  issuer_state_t       state;
  issuer_state_t       state_nxt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W-1:0] tmo_nxt;
  logic                status;
  logic                status_nxt;
  logic [15:0]         issued_cnt;

  assign push_data.opcode   = cmd_opcode_i;
  assign push_data.src_addr = cmd_src_addr_i;
  assign push_data.rvalid   = cmd_rvalid_i;
  assign push_data.dst_addr = cmd_dst_addr_i;

  vpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid_i),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Ready comes straight from the registered full flag, so a same-cycle pop never frees a slot early.
  assign cmd_ready_o    = !full;
  assign req_valid_o    = (state == S_REQ);
  assign rsp_valid_o    = (state == S_RSP);
  assign rsp_timeout_o  = (state == S_RSP) && status;
  assign busy_o         = (state != S_IDLE) || !empty;
  assign issued_cnt_o   = issued_cnt;
  assign req_opcode_o   = req_q.opcode;
  assign req_src_addr_o = req_q.src_addr;
  assign req_rvalid_o   = req_q.rvalid;
  assign req_dst_addr_o = req_q.dst_addr;

  // Next-state logic: pop in idle, hold the request until handshake, wait for write-back or timeout.
  always_comb begin
    state_nxt  = state;
    tmo_nxt    = tmo_cnt;
    status_nxt = status;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready_i) begin
          tmo_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_nxt = tmo_cnt + TIMEOUT_W'(1);
        // A completion arriving on the saturating cycle still counts as success.
        if (wb_done_i) begin
          status_nxt = 1'b0;
          state_nxt  = S_RSP;
        end else if (tmo_nxt == '1) begin
          status_nxt = 1'b1;
          state_nxt  = S_RSP;
        end
      end
      S_RSP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, timeout, status, held request and accepted-request counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      status     <= 1'b0;
      req_q      <= '0;
      issued_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      status  <= status_nxt;
      if (pop) begin
        req_q <= head;
      end
      if (state == S_REQ && req_ready_i) begin
        issued_cnt <= issued_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vpu_req_issuer.sv
// tb/tb_vpu_req_issuer.sv - randomized and directed bench against a transaction-level model
module tb_vpu_req_issuer;
  import vpu_req_issuer_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;

  // Lifecycle of the transaction currently owned by the issuer.
  localparam int T_NONE    = 0;
  localparam int T_OFFERED = 1;
  localparam int T_WAITING = 2;
  localparam int T_ANSWER  = 3;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] src;
    logic [1:0]  rv;
    logic [15:0] dst;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [4:0]  cmd_opcode_i = '0;
  logic [31:0] cmd_src_addr_i = '0;
  logic [1:0]  cmd_rvalid_i = '0;
  logic [15:0] cmd_dst_addr_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [4:0]  req_opcode_o;
  logic [31:0] req_src_addr_o;
  logic [1:0]  req_rvalid_o;
  logic [15:0] req_dst_addr_o;
  logic        wb_done_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic [15:0] issued_cnt_o;

  vpu_req_issuer #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_opcode_i   (cmd_opcode_i),
    .cmd_src_addr_i (cmd_src_addr_i),
    .cmd_rvalid_i   (cmd_rvalid_i),
    .cmd_dst_addr_i (cmd_dst_addr_i),
    .req_valid_o    (req_valid_o),
    .req_ready_i    (req_ready_i),
    .req_opcode_o   (req_opcode_o),
    .req_src_addr_o (req_src_addr_o),
    .req_rvalid_o   (req_rvalid_o),
    .req_dst_addr_o (req_dst_addr_o),
    .wb_done_i      (wb_done_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_timeout_o  (rsp_timeout_o),
    .busy_o         (busy_o),
    .issued_cnt_o   (issued_cnt_o)
  );

  always #5 clk = ~clk;

  cmd_t q[$];
  cmd_t cur = '0;
  int   phase = T_NONE;
  int   waited = 0;
  bit   timed_out = 1'b0;
  int   issued = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cmd_t rand_cmd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[54:0];
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then compare outputs.
  task automatic step(input bit rst, input bit cv, input cmd_t c, input bit rr, input bit wd);
    bit push;
    rst_n          = !rst;
    cmd_valid_i    = cv;
    cmd_opcode_i   = c.op;
    cmd_src_addr_i = c.src;
    cmd_rvalid_i   = c.rv;
    cmd_dst_addr_i = c.dst;
    req_ready_i    = rr;
    wb_done_i      = wd;
    @(posedge clk);
    if (rst) begin
      q.delete();
      phase     = T_NONE;
      cur       = '0;
      issued    = 0;
      waited    = 0;
      timed_out = 1'b0;
    end else begin
      push = cv && (q.size() < DEPTH);
      case (phase)
        T_NONE: begin
          if (q.size() > 0) begin
            cur   = q.pop_front();
            phase = T_OFFERED;
          end
        end
        T_OFFERED: begin
          if (rr) begin
            issued = (issued + 1) & 16'hFFFF;
            waited = 0;
            phase  = T_WAITING;
          end
        end
        T_WAITING: begin
          waited++;
          if (wd) begin
            timed_out = 1'b0;
            phase     = T_ANSWER;
          end else if (waited == LIMIT) begin
            timed_out = 1'b1;
            phase     = T_ANSWER;
          end
        end
        default: phase = T_NONE;
      endcase
      if (push) q.push_back(c);
    end
    @(negedge clk);
    check("cmd_ready", 64'(cmd_ready_o), 64'(q.size() < DEPTH));
    check("req_valid", 64'(req_valid_o), 64'(phase == T_OFFERED));
    check("req_fields", 64'({req_opcode_o, req_src_addr_o, req_rvalid_o, req_dst_addr_o}), 64'(cur));
    check("rsp_valid", 64'(rsp_valid_o), 64'(phase == T_ANSWER));
    check("rsp_timeout", 64'(rsp_timeout_o), 64'(phase == T_ANSWER && timed_out));
    check("busy", 64'(busy_o), 64'(phase != T_NONE || q.size() > 0));
    check("issued_cnt", 64'(issued_cnt_o), 64'(issued));
  endtask

  // Run with the controller always ready until everything drains; the first skip_n
  // requests never see a completion, later ones see it on their (wd_at+1)-th wait cycle.
  task automatic drain(input int wd_at, input int skip_n);
    int start;
    start = issued;
    for (int k = 0; k < 120; k++) begin
      if (phase == T_NONE && q.size() == 0) break;
      step(0, 0, rand_cmd(), 1, phase == T_WAITING && waited == wd_at && (issued - start) > skip_n);
    end
  endtask

  cmd_t c1;
  cmd_t burst[5];
  int   stall;
  bit   acc;

  initial begin
    step(1, 0, '0, 0, 0);
    step(1, 1, rand_cmd(), 1, 1);

    // Single command, completion on the 5th wait cycle.
    c1.op  = 5'd3;
    c1.src = {16'h0020, 16'h0010};
    c1.rv  = 2'b11;
    c1.dst = 16'h0030;
    step(0, 1, c1, 1, 0);
    drain(4, 0);

    // Controller stalls 7 cycles while the request is offered.
    step(0, 1, rand_cmd(), 0, 0);
    stall = 0;
    for (int k = 0; k < 40; k++) begin
      if (phase == T_NONE && q.size() == 0) break;
      step(0, 0, rand_cmd(), phase == T_OFFERED && stall >= 7, phase == T_WAITING && waited == 2);
      if (phase == T_OFFERED) stall++;
    end

    // Five back-to-back pushes behind a stalled request; the fifth waits for a pop.
    step(0, 1, rand_cmd(), 0, 0);
    for (int i = 0; i < 5; i++) begin
      burst[i] = rand_cmd();
      for (int k = 0; k < 60; k++) begin
        acc = (q.size() < DEPTH);
        step(0, 1, burst[i], i == 4, phase == T_WAITING);
        if (acc) break;
      end
    end
    drain(1, 0);

    // Timeout followed by a normally completing queued command; rvalid=0 still issues.
    c1    = rand_cmd();
    c1.rv = 2'b00;
    step(0, 1, c1, 0, 0);
    step(0, 1, rand_cmd(), 0, 0);
    drain(3, 1);

    // Completion on the same cycle the counter saturates.
    step(0, 1, rand_cmd(), 1, 0);
    drain(LIMIT - 1, 0);

    // Reset while waiting with two commands queued.
    step(0, 1, rand_cmd(), 0, 0);
    step(0, 1, rand_cmd(), 0, 0);
    step(0, 1, rand_cmd(), 1, 0);
    step(0, 0, rand_cmd(), 1, 0);
    step(1, 0, rand_cmd(), 1, 0);
    repeat (6) step(0, 0, rand_cmd(), 1, 1);

    // Randomized traffic with occasional resets.
    repeat (4000) begin
      step(($urandom % 300) == 0, ($urandom % 100) < 45, rand_cmd(),
           ($urandom % 100) < 60, ($urandom % 100) < 14);
    end
    drain(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vpu_req_issuer.md
Name: vpu_req_issuer

Overview:
Request-side initiator for the VPU request interface; it drives the interface that the VPU controller consumes. It buffers host commands in a small FIFO and presents one request at a time with a valid/ready handshake. It then waits for the controller's write-back completion and returns a one-cycle response with completion or timeout status. Only one request is outstanding at a time, matching the controller's IDLE→GETOP→EXEC→WB sequence.

Parameters:
- SRAM_R_PORT_CNT, 2, number of operand read ports (one rvalid bit each).
- ADDR_W, 16, SRAM address width.
- OP_W, 5, opcode width.
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2).
- TIMEOUT_W, 12, width of the completion-timeout counter; timeout fires at 2^TIMEOUT_W−1 cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- cmd_valid_i  in  1  host command valid.
- cmd_ready_o  out  1  FIFO not full.
- cmd_opcode_i  in  OP_W  opcode.
- cmd_src_addr_i  in  SRAM_R_PORT_CNT*ADDR_W  packed source addresses; port k at [k*ADDR_W +: ADDR_W].
- cmd_rvalid_i  in  SRAM_R_PORT_CNT  source port enables.
- cmd_dst_addr_i  in  ADDR_W  write-back address.
- req_valid_o  out  1  request valid to controller.
- req_ready_i  in  1  controller ready (high only in its IDLE state).
- req_opcode_o  out  OP_W  issued opcode.
- req_src_addr_o  out  SRAM_R_PORT_CNT*ADDR_W  issued source addresses.
- req_rvalid_o  out  SRAM_R_PORT_CNT  issued port enables.
- req_dst_addr_o  out  ADDR_W  issued destination.
- wb_done_i  in  1  controller write-back completion pulse.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_timeout_o  out  1  qualifies rsp_valid_o; 1 means timed out.
- busy_o  out  1  FSM not in S_IDLE or FIFO not empty.
- issued_cnt_o  out  16  count of accepted requests; wraps at 0xFFFF→0.

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o = 1. FIFO is emptied, FSM goes to S_IDLE, counters clear. Reset mid-operation drops any in-flight request and all queued commands; no response is generated.
- FIFO push happens when cmd_valid_i && cmd_ready_o. Pop happens only in the S_IDLE→S_REQ transition. A push and a pop in the same cycle are both honoured.
  - When the FIFO is full, cmd_ready_o = 0 and a push is ignored.
  - cmd_ready_o is driven combinationally from the full flag, so a simultaneous pop does not free the slot in that cycle.
- FSM:
  - S_IDLE: when the FIFO is not empty, pop the head into the output registers and go to S_REQ. The request appears on req_* one cycle after the pop; there is no combinational path from FIFO to req_*.
  - S_REQ: req_valid_o = 1. All req_* fields stay stable until the handshake. On req_valid_o && req_ready_i, increment issued_cnt_o, clear the timeout counter and go to S_WAIT. req_valid_o drops the next cycle.
  - S_WAIT: increment the timeout counter each cycle.
    - On wb_done_i: go to S_RSP with status 0.
    - Else, when the counter reaches all-ones: go to S_RSP with status 1.
    - If wb_done_i arrives in the same cycle the counter saturates, wb_done_i wins (status 0).
  - S_RSP: rsp_valid_o = 1 for exactly one cycle, rsp_timeout_o = status, then go to S_IDLE.
- Minimum spacing between back-to-back requests: S_RSP→S_IDLE→S_REQ gives req_valid_o rising 2 cycles after rsp_valid_o.
- wb_done_i outside S_WAIT is ignored.
- req_ready_i outside S_REQ is ignored.
- req_rvalid_o is passed through unchanged. A command with rvalid = 0 is still issued.
- No req_valid_o deassertion without a handshake; timeout applies only to S_WAIT.

Decomposition:
- VPU_PKG additions:
  - SRAM_R_PORT_CNT (already present), ADDR_W, OP_W.
  - vpu_req_t struct {opcode, src_addr[SRAM_R_PORT_CNT], rvalid, dst_addr}.
  - Issuer state enum {S_IDLE, S_REQ, S_WAIT, S_RSP}.
- Sub-module vpu_cmd_fifo: synchronous FIFO of vpu_req_t, depth FIFO_DEPTH, with full/empty flags and pointer wrap via an extra MSB.

Test Plan:
- Single command (op=3, src={0x10,0x20}, rvalid=2'b11, dst=0x30), req_ready_i tied high, wb_done_i 5 cycles after the handshake → req_valid_o high exactly 1 cycle with those field values; rsp_valid_o=1, rsp_timeout_o=0; issued_cnt_o=1.
- req_ready_i held low for 7 cycles while req_valid_o is high → req_* fields stable for all 7 cycles; handshake on cycle 8; issued_cnt_o increments once.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and the controller stalled → cmd_ready_o drops after the 4th push; the 5th is accepted only after the first pop; all 5 issue in order.
- TIMEOUT_W=4, wb_done_i never asserted → rsp_valid_o with rsp_timeout_o=1 on the 16th cycle after the handshake; the next queued command then issues normally.
- wb_done_i asserted in the same cycle the counter saturates → rsp_timeout_o=0.
- rst_n low for 1 cycle while in S_WAIT with 2 commands queued → all outputs reset, cmd_ready_o=1, busy_o=0, no rsp_valid_o afterwards; issued_cnt_o=0.
